// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and constants for the branch predictor. Holds
//               the BHT/BTB entry layouts, the 2-bit counter encodings and a
//               saturating counter helper. The entry layouts are sized for
//               the default geometry (16-bit PC, 8 entries).
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int BP_PC_W    = 16;
    localparam int BP_INDEX_W = 3;
    // Tag covers every PC bit above the index; bit 0 is always zero.
    localparam int TAG_W      = BP_PC_W - BP_INDEX_W - 1;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
    } bht_entry_t;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] target;
    } btb_entry_t;

    localparam bht_entry_t BHT_RESET = '{valid: 1'b0, tag: '0, ctr: CTR_WNT};
    localparam btb_entry_t BTB_RESET = '{tvalid: 1'b0, target: '0};

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                nxt = ctr + 2'b01;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nxt = ctr - 2'b01;
            end
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_entry_table.sv
`default_nettype none
// ============================================================================
// Module      : bp_entry_table
// Description : Register-array table with synchronous clear.
//               Ports:
//                 clk, rst          - clock, synchronous active-high clear
//                 i_raddr / o_rdata - asynchronous lookup read port
//                 i_wen, i_waddr,
//                 i_wdata           - synchronous write port
//                 o_wold            - current contents at i_waddr, so the
//                                     write port can do read-modify-write
//               Clear has priority over a write in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_entry_table #(
    parameter int               WIDTH   = 8,
    parameter int               ADDR_W  = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_wold
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // No write-to-read bypass: reads always see pre-edge contents.
    assign o_rdata = r_mem[i_raddr];
    assign o_wold  = r_mem[i_waddr];

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Direct-mapped dynamic branch predictor. A BHT of 2-bit
//               saturating counters plus a BTB of targets, looked up
//               combinationally by fetch and updated by decode.
//               Ports:
//                 clk, rst                  - clock, sync active-high reset
//                 enable, PC_curr           - fetch lookup
//                 prediction,
//                 predicted_target          - lookup result
//                 IF_ID_PC_curr             - resolving branch PC
//                 wen_BHT, actual_taken,
//                 mispredicted              - direction update
//                 wen_BTB, branch_target    - target update
//                 br_count, mispred_count   - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int INDEX_W = BP_INDEX_W,
    parameter int PC_W    = BP_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [PC_W-1:0] PC_curr,
    output logic            prediction,
    output logic [PC_W-1:0] predicted_target,
    input  logic [PC_W-1:0] IF_ID_PC_curr,
    input  logic            wen_BHT,
    input  logic            actual_taken,
    input  logic            wen_BTB,
    input  logic [PC_W-1:0] branch_target,
    input  logic            mispredicted,
    output logic [15:0]     br_count,
    output logic [15:0]     mispred_count
);

    logic [INDEX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [INDEX_W-1:0] w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;

    bht_entry_t w_lk_bht;
    bht_entry_t w_up_bht;
    bht_entry_t w_bht_wdata;
    btb_entry_t w_lk_btb;
    btb_entry_t w_up_btb;
    btb_entry_t w_btb_wdata;

    logic w_bht_wen;
    logic w_btb_wen;
    logic w_lk_hit;
    logic w_up_match;
    logic w_unused_bits;

    logic [15:0] r_br_count;
    logic [15:0] r_mispred_count;

    // PC bit 0 is always zero, so the index starts at bit 1.
    assign w_lk_idx = PC_curr[INDEX_W:1];
    assign w_lk_tag = PC_curr[PC_W-1:INDEX_W+1];
    assign w_up_idx = IF_ID_PC_curr[INDEX_W:1];
    assign w_up_tag = IF_ID_PC_curr[PC_W-1:INDEX_W+1];

    bp_entry_table #(
        .WIDTH   ($bits(bht_entry_t)),
        .ADDR_W  (INDEX_W),
        .RST_VAL (BHT_RESET)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .i_raddr (w_lk_idx),
        .o_rdata (w_lk_bht),
        .i_wen   (w_bht_wen),
        .i_waddr (w_up_idx),
        .i_wdata (w_bht_wdata),
        .o_wold  (w_up_bht)
    );

    bp_entry_table #(
        .WIDTH   ($bits(btb_entry_t)),
        .ADDR_W  (INDEX_W),
        .RST_VAL (BTB_RESET)
    ) u_btb (
        .clk     (clk),
        .rst     (rst),
        .i_raddr (w_lk_idx),
        .o_rdata (w_lk_btb),
        .i_wen   (w_btb_wen),
        .i_waddr (w_up_idx),
        .i_wdata (w_btb_wdata),
        .o_wold  (w_up_btb)
    );

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    assign w_lk_hit         = w_lk_bht.valid && (w_lk_bht.tag == w_lk_tag);
    assign prediction       = enable & w_lk_hit & w_lk_bht.ctr[1] & w_lk_btb.tvalid;
    assign predicted_target = prediction ? w_lk_btb.target : '0;

    // ------------------------------------------------------------------
    // Update / allocation
    // ------------------------------------------------------------------
    assign w_up_match = w_up_bht.valid && (w_up_bht.tag == w_up_tag);

    always_comb begin
        w_bht_wen   = 1'b0;
        w_bht_wdata = w_up_bht;
        w_btb_wen   = 1'b0;
        w_btb_wdata = w_up_btb;

        if (wen_BHT) begin
            w_bht_wen = 1'b1;
            if (w_up_match) begin
                w_bht_wdata.ctr = ctr_next(w_up_bht.ctr, actual_taken);
            end else begin
                w_bht_wdata.valid = 1'b1;
                w_bht_wdata.tag   = w_up_tag;
                w_bht_wdata.ctr   = actual_taken ? CTR_WT : CTR_WNT;
                // The old target belongs to the evicted branch; drop it
                // unless a fresh target is arriving this cycle.
                if (!wen_BTB) begin
                    w_btb_wen          = 1'b1;
                    w_btb_wdata.tvalid = 1'b0;
                end
            end
        end else if (wen_BTB && !w_up_match) begin
            // Target-only write to a foreign entry claims it as weakly taken.
            w_bht_wen         = 1'b1;
            w_bht_wdata.valid = 1'b1;
            w_bht_wdata.tag   = w_up_tag;
            w_bht_wdata.ctr   = CTR_WT;
        end

        if (wen_BTB) begin
            w_btb_wen          = 1'b1;
            w_btb_wdata.tvalid = 1'b1;
            w_btb_wdata.target = branch_target;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (wen_BHT) begin
            if (r_br_count != 16'hFFFF) begin
                r_br_count <= r_br_count + 16'd1;
            end
            if (mispredicted && (r_mispred_count != 16'hFFFF)) begin
                r_mispred_count <= r_mispred_count + 16'd1;
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

    assign w_unused_bits = ^{PC_curr[0], IF_ID_PC_curr[0], w_lk_bht.ctr[0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit. A behavioural
//               table model predicts lookup results and statistics; directed
//               scenarios plus randomized traffic exercise the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] PC_curr;
    logic        prediction;
    logic [15:0] predicted_target;
    logic [15:0] IF_ID_PC_curr;
    logic        wen_BHT;
    logic        actual_taken;
    logic        wen_BTB;
    logic [15:0] branch_target;
    logic        mispredicted;
    logic [15:0] br_count;
    logic [15:0] mispred_count;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .PC_curr          (PC_curr),
        .prediction       (prediction),
        .predicted_target (predicted_target),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .wen_BHT          (wen_BHT),
        .actual_taken     (actual_taken),
        .wen_BTB          (wen_BTB),
        .branch_target    (branch_target),
        .mispredicted     (mispredicted),
        .br_count         (br_count),
        .mispred_count    (mispred_count)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: one slot per index, plain integers.
    bit m_valid [8];
    int m_tag   [8];
    int m_ctr   [8];
    bit m_tv    [8];
    int m_tgt   [8];
    int m_br;
    int m_mp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
            m_tv[i]    = 1'b0;
            m_tgt[i]   = 0;
        end
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void model_pred(input logic [15:0] pc, input bit en,
                                       output bit p, output int tgt);
        int i;
        int t;
        i   = (int'(pc) >> 1) & 7;
        t   = int'(pc) >> 4;
        p   = en && m_valid[i] && (m_tag[i] == t) && (m_ctr[i] >= 2) && m_tv[i];
        tgt = p ? m_tgt[i] : 0;
    endfunction

    function automatic void model_update(input bit r, input logic [15:0] upc, input bit wb,
                                         input bit tk, input bit wt, input logic [15:0] bt,
                                         input bit mp);
        int  i;
        int  t;
        bit  match;
        if (r) begin
            model_reset();
            return;
        end
        i     = (int'(upc) >> 1) & 7;
        t     = int'(upc) >> 4;
        match = m_valid[i] && (m_tag[i] == t);
        if (wb) begin
            if (m_br < 65535) m_br++;
            if (mp && m_mp < 65535) m_mp++;
            if (match) begin
                m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_ctr[i]   = tk ? 2 : 1;
                if (!wt) m_tv[i] = 1'b0;
            end
        end
        if (wt) begin
            m_tgt[i] = int'(bt);
            m_tv[i]  = 1'b1;
            if (!wb && !match) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_ctr[i]   = 2;
            end
        end
    endfunction

    // One clock cycle: drive, optionally check pre-edge outputs, clock, update model.
    task automatic step(input bit r, input bit en, input logic [15:0] pc,
                        input logic [15:0] upc, input bit wb, input bit tk,
                        input bit wt, input logic [15:0] bt, input bit mp, input bit chk);
        bit ep;
        int et;
        rst           = r;
        enable        = en;
        PC_curr       = pc;
        IF_ID_PC_curr = upc;
        wen_BHT       = wb;
        actual_taken  = tk;
        wen_BTB       = wt;
        branch_target = bt;
        mispredicted  = mp;
        #1;
        if (chk) begin
            model_pred(pc, en, ep, et);
            check_eq("prediction", {31'd0, prediction}, {31'd0, ep});
            check_eq("predicted_target", {16'd0, predicted_target}, et);
            check_eq("br_count", {16'd0, br_count}, m_br);
            check_eq("mispred_count", {16'd0, mispred_count}, m_mp);
        end
        @(posedge clk);
        model_update(r, upc, wb, tk, wt, bt, mp);
        @(negedge clk);
    endtask

    // Resolve a branch at upc while fetch also looks it up.
    task automatic upd(input logic [15:0] upc, input bit tk, input bit wt,
                       input logic [15:0] bt, input bit mp);
        step(1'b0, 1'b1, upc, upc, 1'b1, tk, wt, bt, mp, 1'b1);
    endtask

    // Lookup-only probe against literal expectations; no clock edge.
    task automatic peek(input string tag, input logic [15:0] pc, input bit en,
                        input bit exp_p, input logic [15:0] exp_t);
        rst = 1'b0; enable = en; PC_curr = pc; IF_ID_PC_curr = 16'h0;
        wen_BHT = 1'b0; wen_BTB = 1'b0; actual_taken = 1'b0;
        branch_target = 16'h0; mispredicted = 1'b0;
        #1;
        check_eq({tag, "_pred"}, {31'd0, prediction}, {31'd0, exp_p});
        check_eq({tag, "_tgt"}, {16'd0, predicted_target}, {16'd0, exp_t});
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; PC_curr = '0; IF_ID_PC_curr = '0;
        wen_BHT = 1'b0; actual_taken = 1'b0; wen_BTB = 1'b0;
        branch_target = '0; mispredicted = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        peek("reset", 16'h0004, 1'b1, 1'b0, 16'h0000);
        check_eq("reset_br_count", {16'd0, br_count}, 32'd0);

        // First allocation with target
        upd(16'h0004, 1'b1, 1'b1, 16'h0040, 1'b0);
        peek("alloc", 16'h0004, 1'b1, 1'b1, 16'h0040);
        check_eq("alloc_br_count", {16'd0, br_count}, 32'd1);

        // 10 -> 01 -> 00, then up to 11 and saturate
        upd(16'h0004, 1'b0, 1'b0, 16'h0, 1'b1);
        upd(16'h0004, 1'b0, 1'b0, 16'h0, 1'b0);
        peek("ctr00", 16'h0004, 1'b1, 1'b0, 16'h0000);
        upd(16'h0004, 1'b1, 1'b0, 16'h0, 1'b1);
        peek("ctr01", 16'h0004, 1'b1, 1'b0, 16'h0000);
        upd(16'h0004, 1'b1, 1'b0, 16'h0, 1'b0);
        upd(16'h0004, 1'b1, 1'b0, 16'h0, 1'b0);
        upd(16'h0004, 1'b1, 1'b0, 16'h0, 1'b0);
        upd(16'h0004, 1'b0, 1'b0, 16'h0, 1'b0);
        peek("ctr_sat_hi", 16'h0004, 1'b1, 1'b1, 16'h0040);
        upd(16'h0004, 1'b0, 1'b0, 16'h0, 1'b0);
        peek("ctr_back01", 16'h0004, 1'b1, 1'b0, 16'h0000);

        // Aliasing: 0x0014 evicts 0x0004 at index 2
        upd(16'h0004, 1'b1, 1'b1, 16'h0040, 1'b0);
        upd(16'h0014, 1'b0, 1'b0, 16'h0, 1'b0);
        peek("evicted", 16'h0004, 1'b1, 1'b0, 16'h0000);
        peek("alias_new", 16'h0014, 1'b1, 1'b0, 16'h0000);

        // Same-cycle update and lookup: old contents, then new
        rst = 1'b0; enable = 1'b1; PC_curr = 16'h0004; IF_ID_PC_curr = 16'h0004;
        wen_BHT = 1'b1; actual_taken = 1'b1; wen_BTB = 1'b1;
        branch_target = 16'h0088; mispredicted = 1'b0;
        #1;
        check_eq("no_bypass_pred", {31'd0, prediction}, 32'd0);
        @(posedge clk);
        model_update(1'b0, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0088, 1'b0);
        @(negedge clk);
        peek("after_write", 16'h0004, 1'b1, 1'b1, 16'h0088);

        // Reset wins over a concurrent update
        step(1'b1, 1'b1, 16'h0004, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h0077, 1'b1, 1'b1);
        peek("rst_wins", 16'h0004, 1'b1, 1'b0, 16'h0000);
        check_eq("rst_wins_br", {16'd0, br_count}, 32'd0);
        check_eq("rst_wins_mp", {16'd0, mispred_count}, 32'd0);

        // enable low masks a known hit
        upd(16'h0004, 1'b1, 1'b1, 16'h0040, 1'b0);
        peek("disabled", 16'h0004, 1'b0, 1'b0, 16'h0000);
        peek("enabled", 16'h0004, 1'b1, 1'b1, 16'h0040);

        // Randomized traffic over a small tag set to get frequent hits
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] lpc;
            logic [15:0] upc;
            lpc = 16'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 7) << 1));
            upc = 16'(($urandom_range(0, 2) << 4) | ($urandom_range(0, 7) << 1));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), lpc, upc,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, 16'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 1) == 1, 1'b1);
        end

        // Statistics saturation
        for (int n = 0; n < 65540; n++) begin
            step(1'b0, 1'b1, 16'h0000, 16'(($urandom_range(0, 7)) << 1), 1'b1,
                 $urandom_range(0, 1) == 1, 1'b0, 16'h0, 1'b1, 1'b0);
        end
        #1;
        check_eq("sat_br_count", {16'd0, br_count}, 32'h0000FFFF);
        check_eq("sat_mispred_count", {16'd0, mispred_count}, 32'h0000FFFF);
        step(1'b0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        #1;
        check_eq("sat_hold_br", {16'd0, br_count}, 32'h0000FFFF);
        check_eq("sat_hold_mp", {16'd0, mispred_count}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
